// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit datapath.
// Holds the instruction register and PSR and drives every datapath select/enable.
module cpu_sequencer #(
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [4:0]  flags,
    output logic [15:0] opcode,
    output logic [3:0]  mux_a_sel,
    output logic [3:0]  mux_b_sel,
    output logic        alu_sel,
    output logic        pc_sel,
    output logic        w_en_a,
    output logic        w_en_b,
    output logic [15:0] reg_en,
    output logic        flag_en,
    output logic        pc_en,
    output logic        pc_ld,
    output logic [4:0]  psr,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_LOADWB = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir;
    logic [4:0]  psr_q;

    logic [3:0] ir_cls, ir_rd, ir_ext, ir_rs;
    logic       is_alu, is_cmp, is_load, is_stor, is_jcond;
    logic       cond_true;

    logic [15:0] reg_en_raw;
    logic        w_en_a_raw, flag_en_raw, pc_en_raw, pc_ld_raw;

    assign ir_cls = ir[15:12];
    assign ir_rd  = ir[11:8];
    assign ir_ext = ir[7:4];
    assign ir_rs  = ir[3:0];

    assign is_alu   = (ir_cls == 4'b0000);
    assign is_cmp   = is_alu && (ir_ext == 4'b1011);
    assign is_load  = (ir_cls == 4'b0100) && (ir_ext == 4'b0000);
    assign is_stor  = (ir_cls == 4'b0100) && (ir_ext == 4'b0100);
    assign is_jcond = (ir_cls == 4'b0100) && (ir_ext == 4'b1100);

    // PSR layout {N,Z,F,L,C}; conditions look only at the registered copy.
    always_comb begin
        cond_true = 1'b0;
        case (ir_rd)
            4'b0000: cond_true =  psr_q[3];
            4'b0001: cond_true = ~psr_q[3];
            4'b0010: cond_true =  psr_q[0];
            4'b0011: cond_true = ~psr_q[0];
            4'b0100: cond_true =  psr_q[1];
            4'b0101: cond_true = ~psr_q[1];
            4'b0110: cond_true =  psr_q[4];
            4'b0111: cond_true = ~psr_q[4];
            4'b1000: cond_true =  psr_q[2];
            4'b1001: cond_true = ~psr_q[2];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir      <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                ir <= instr;
            if (flag_en_raw)
                psr_q <= flags;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode      = '0;
        mux_a_sel   = '0;
        mux_b_sel   = '0;
        alu_sel     = 1'b0;
        pc_sel      = 1'b0;
        w_en_a_raw  = 1'b0;
        reg_en_raw  = '0;
        flag_en_raw = 1'b0;
        pc_en_raw   = 1'b0;
        pc_ld_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                pc_sel  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pc_en_raw = 1'b1;
                state_d   = (instr == HALT_WORD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu) begin
                    opcode      = ir;
                    mux_a_sel   = ir_rd;
                    mux_b_sel   = ir_rs;
                    alu_sel     = 1'b1;
                    flag_en_raw = 1'b1;
                    if (!is_cmp)
                        reg_en_raw = 16'(1) << ir_rd;
                end else if (is_stor) begin
                    mux_a_sel  = ir_rs;
                    mux_b_sel  = ir_rd;
                    w_en_a_raw = 1'b1;
                end else if (is_load) begin
                    mux_a_sel = ir_rs;
                    state_d   = S_LOADWB;
                end else if (is_jcond) begin
                    mux_a_sel = ir_rs;
                    pc_en_raw = cond_true;
                    pc_ld_raw = cond_true;
                end
            end
            S_LOADWB: begin
                mux_a_sel  = ir_rs;
                reg_en_raw = 16'(1) << ir_rd;
                state_d    = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset is synchronous, so write strobes are masked combinationally while it is held.
    assign reg_en  = reset ? '0 : reg_en_raw;
    assign w_en_a  = w_en_a_raw  & ~reset;
    assign flag_en = flag_en_raw & ~reset;
    assign pc_en   = pc_en_raw   & ~reset;
    assign pc_ld   = pc_ld_raw   & ~reset;
    assign w_en_b  = 1'b0;
    assign psr     = psr_q;
    assign halted  = (state_q == S_HALT);
    assign state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: one task per scenario,
// outputs sampled 1 time unit after each rising clock edge.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic [15:0] opcode;
    logic [3:0]  mux_a_sel;
    logic [3:0]  mux_b_sel;
    logic        alu_sel;
    logic        pc_sel;
    logic        w_en_a;
    logic        w_en_b;
    logic [15:0] reg_en;
    logic        flag_en;
    logic        pc_en;
    logic        pc_ld;
    logic [4:0]  psr;
    logic        halted;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    cpu_sequencer #(.HALT_WORD(16'hFFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .flags     (flags),
        .opcode    (opcode),
        .mux_a_sel (mux_a_sel),
        .mux_b_sel (mux_b_sel),
        .alu_sel   (alu_sel),
        .pc_sel    (pc_sel),
        .w_en_a    (w_en_a),
        .w_en_b    (w_en_b),
        .reg_en    (reg_en),
        .flag_en   (flag_en),
        .pc_en     (pc_en),
        .pc_ld     (pc_ld),
        .psr       (psr),
        .halted    (halted),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: present w during FETCH, latch it in DECODE, return sampled in EXEC.
    task automatic run_to_exec(input logic [15:0] w);
        instr = w;
        tick();
        tick();
        instr = 16'h7000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (pc_sel !== 1'b1) begin failures++; $display("FAIL rst_pc_sel got=%0b exp=1", pc_sel); end
        checks++; if (reg_en !== 16'h0000) begin failures++; $display("FAIL rst_reg_en got=%h exp=0000", reg_en); end
        checks++; if (psr !== 5'b00000) begin failures++; $display("FAIL rst_psr got=%b exp=00000", psr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0b exp=0", halted); end
        checks++; if (w_en_b !== 1'b0) begin failures++; $display("FAIL rst_w_en_b got=%0b exp=0", w_en_b); end
        // reset landing in LOADWB
        run_to_exec(16'h4205);
        tick();
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL rstwb_state got=%0d exp=3", state); end
        reset = 1'b1;
        #1;
        checks++; if (reg_en !== 16'h0000) begin failures++; $display("FAIL rstwb_reg_en got=%h exp=0000", reg_en); end
        tick();
        reset = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rstwb_next got=%0d exp=0", state); end
    endtask

    task automatic test_add();
        instr = 16'h0153;
        tick();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL add_decode_state got=%0d exp=1", state); end
        checks++; if (pc_en !== 1'b1 || pc_ld !== 1'b0) begin failures++; $display("FAIL add_decode_pc got=%0b%0b exp=10", pc_en, pc_ld); end
        tick();
        instr = 16'h7000;
        flags = 5'b00001;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL add_exec_state got=%0d exp=2", state); end
        checks++; if (mux_a_sel !== 4'd1) begin failures++; $display("FAIL add_mux_a got=%0h exp=1", mux_a_sel); end
        checks++; if (mux_b_sel !== 4'd3) begin failures++; $display("FAIL add_mux_b got=%0h exp=3", mux_b_sel); end
        checks++; if (alu_sel !== 1'b1) begin failures++; $display("FAIL add_alu_sel got=%0b exp=1", alu_sel); end
        checks++; if (reg_en !== 16'h0002) begin failures++; $display("FAIL add_reg_en got=%h exp=0002", reg_en); end
        checks++; if (flag_en !== 1'b1) begin failures++; $display("FAIL add_flag_en got=%0b exp=1", flag_en); end
        checks++; if (opcode !== 16'h0153) begin failures++; $display("FAIL add_opcode got=%h exp=0153", opcode); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL add_pc_en got=%0b exp=0", pc_en); end
        tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL add_back_fetch got=%0d exp=0", state); end
        checks++; if (psr !== 5'b00001) begin failures++; $display("FAIL add_psr got=%b exp=00001", psr); end
        checks++; if (opcode !== 16'h0000) begin failures++; $display("FAIL add_fetch_opcode got=%h exp=0000", opcode); end
    endtask

    task automatic test_cmp_jcond();
        run_to_exec(16'h02B4);
        flags = 5'b01000;
        checks++; if (reg_en !== 16'h0000) begin failures++; $display("FAIL cmp_reg_en got=%h exp=0000", reg_en); end
        checks++; if (flag_en !== 1'b1) begin failures++; $display("FAIL cmp_flag_en got=%0b exp=1", flag_en); end
        tick();
        checks++; if (psr !== 5'b01000) begin failures++; $display("FAIL cmp_psr got=%b exp=01000", psr); end
        // JEQ taken on PSR.Z even though live Z is now 0
        run_to_exec(16'h40C7);
        flags = 5'b00000;
        #1;
        checks++; if (pc_en !== 1'b1 || pc_ld !== 1'b1) begin failures++; $display("FAIL jeq_taken got=%0b%0b exp=11", pc_en, pc_ld); end
        checks++; if (mux_a_sel !== 4'd7) begin failures++; $display("FAIL jeq_mux_a got=%0h exp=7", mux_a_sel); end
        checks++; if (opcode !== 16'h0000 || flag_en !== 1'b0) begin failures++; $display("FAIL jeq_opcode got=%h/%0b exp=0000/0", opcode, flag_en); end
        tick();
        checks++; if (psr !== 5'b01000) begin failures++; $display("FAIL jeq_psr_kept got=%b exp=01000", psr); end
        run_to_exec(16'h0153);
        flags = 5'b00000;
        tick();
        checks++; if (psr !== 5'b00000) begin failures++; $display("FAIL clrz_psr got=%b exp=00000", psr); end
        run_to_exec(16'h40C7);
        flags = 5'b01000;
        #1;
        checks++; if (pc_en !== 1'b0 || pc_ld !== 1'b0) begin failures++; $display("FAIL jeq_not_taken got=%0b%0b exp=00", pc_en, pc_ld); end
        tick();
        run_to_exec(16'h41C7);
        checks++; if (pc_en !== 1'b1 || pc_ld !== 1'b1) begin failures++; $display("FAIL jne_taken got=%0b%0b exp=11", pc_en, pc_ld); end
        tick();
        flags = 5'b00000;
    endtask

    task automatic test_load_stor();
        run_to_exec(16'h4205);
        checks++; if (state !== 3'd2 || pc_sel !== 1'b0) begin failures++; $display("FAIL ld_exec got=%0d/%0b exp=2/0", state, pc_sel); end
        checks++; if (mux_a_sel !== 4'd5) begin failures++; $display("FAIL ld_exec_mux_a got=%0h exp=5", mux_a_sel); end
        checks++; if (reg_en !== 16'h0000) begin failures++; $display("FAIL ld_exec_reg_en got=%h exp=0000", reg_en); end
        tick();
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL ld_wb_state got=%0d exp=3", state); end
        checks++; if (alu_sel !== 1'b0 || pc_sel !== 1'b0 || mux_a_sel !== 4'd5) begin failures++; $display("FAIL ld_wb_sel got=%0b%0b/%0h exp=00/5", alu_sel, pc_sel, mux_a_sel); end
        checks++; if (reg_en !== 16'h0004) begin failures++; $display("FAIL ld_wb_reg_en got=%h exp=0004", reg_en); end
        tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL ld_back_fetch got=%0d exp=0", state); end
        run_to_exec(16'h4645);
        checks++; if (w_en_a !== 1'b1) begin failures++; $display("FAIL st_w_en_a got=%0b exp=1", w_en_a); end
        checks++; if (mux_a_sel !== 4'd5 || mux_b_sel !== 4'd6) begin failures++; $display("FAIL st_mux got=%0h/%0h exp=5/6", mux_a_sel, mux_b_sel); end
        checks++; if (pc_sel !== 1'b0 || reg_en !== 16'h0000) begin failures++; $display("FAIL st_other got=%0b/%h exp=0/0000", pc_sel, reg_en); end
        tick();
        checks++; if (state !== 3'd0 || w_en_a !== 1'b0) begin failures++; $display("FAIL st_back_fetch got=%0d/%0b exp=0/0", state, w_en_a); end
    endtask

    task automatic test_jump_nop();
        run_to_exec(16'h4EC2);
        checks++; if (pc_en !== 1'b1 || pc_ld !== 1'b1 || mux_a_sel !== 4'd2) begin failures++; $display("FAIL juc got=%0b%0b/%0h exp=11/2", pc_en, pc_ld, mux_a_sel); end
        tick();
        run_to_exec(16'h4FC2);
        checks++; if (pc_en !== 1'b0 || pc_ld !== 1'b0) begin failures++; $display("FAIL jnever got=%0b%0b exp=00", pc_en, pc_ld); end
        tick();
        run_to_exec(16'h7000);
        flags = 5'b11111;
        #1;
        checks++; if ({reg_en, w_en_a, flag_en, pc_en, pc_ld, alu_sel} !== 21'd0) begin failures++; $display("FAIL nop_strobes got=%h/%0b%0b%0b%0b%0b exp=0", reg_en, w_en_a, flag_en, pc_en, pc_ld, alu_sel); end
        tick();
        checks++; if (psr !== 5'b00000 || state !== 3'd0) begin failures++; $display("FAIL nop_psr got=%b/%0d exp=00000/0", psr, state); end
        flags = 5'b00000;
    endtask

    task automatic test_halt();
        instr = 16'hFFFF;
        tick();
        tick();
        instr = 16'h7000;
        checks++; if (state !== 3'd4 || halted !== 1'b1) begin failures++; $display("FAIL halt_enter got=%0d/%0b exp=4/1", state, halted); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (pc_en !== 1'b0 || state !== 3'd4 || halted !== 1'b1) begin failures++; $display("FAIL halt_hold%0d got=%0b/%0d/%0b exp=0/4/1", i, pc_en, state, halted); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (state !== 3'd0 || halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%0d/%0b exp=0/0", state, halted); end
    endtask

    initial begin
        reset = 1'b1;
        instr = 16'h0000;
        flags = 5'b00000;
        test_reset();
        test_add();
        test_cmp_jcond();
        test_load_stor();
        test_jump_nop();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 16-bit datapath: register bank, two 16:1 operand muxes, ALU, 10-bit program counter and dual-port synchronous memory.
- Drives every datapath select and enable from an internal instruction register and state machine.
- Keeps the architectural flag register (PSR) used for conditional jumps.
- Sits between memory port A output and the datapath control inputs.

Parameters:
- HALT_WORD, 16'hFFFF, instruction encoding that stops the sequencer.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- instr  in  16  memory port A read data (mem_out_a)
- flags  in  5  ALU flags, combinational; {N,Z,F,L,C} = [4:0]
- opcode  out  16  ALU operation word
- mux_a_sel  out  4  operand A register select; also memory address source
- mux_b_sel  out  4  operand B register select; also store data source
- alu_sel  out  1  1 = register write data from ALU; 0 = from memory
- pc_sel  out  1  1 = memory port A address from PC; 0 = from mux A
- w_en_a  out  1  memory port A write enable
- w_en_b  out  1  memory port B write enable; tied 0
- reg_en  out  16  one-hot register write enable
- flag_en  out  1  PSR load strobe (exported for debug)
- pc_en  out  1  PC update enable
- pc_ld  out  1  PC load (1) vs increment (0)
- psr  out  5  registered flags
- halted  out  1  sequencer stopped
- state  out  3  current state encoding (debug)

Behaviour:
- Encoding: IR[15:12] class, IR[11:8] Rd or cond, IR[7:4] ext, IR[3:0] Rs.
  - Class 0000 = ALU: ext 1011 (CMP) writes no register.
  - Class 0100: ext 0000 LOAD Rd <- mem[Rs]; ext 0100 STOR mem[Rs] <- Rd; ext 1100 JCOND cond=IR[11:8], target=Rs[9:0].
  - All other encodings are NOP.
- States: FETCH=0, DECODE=1, EXEC=2, LOADWB=3, HALT=4.
- Outputs are a combinational decode of state and IR. Unlisted outputs are 0.
- FETCH: pc_sel=1. Memory reads from PC. Next state DECODE.
- DECODE: IR <= instr, pc_en=1, pc_ld=0 (PC+1). If instr==HALT_WORD, next state HALT; else EXEC.
- EXEC, ALU:
  - opcode=IR, mux_a_sel=IR[11:8], mux_b_sel=IR[3:0], alu_sel=1, flag_en=1.
  - PSR <= flags at the clock edge.
  - reg_en=1<<IR[11:8], except CMP where reg_en=0.
  - Next state FETCH.
- EXEC, STOR: pc_sel=0, mux_a_sel=IR[3:0], mux_b_sel=IR[11:8], w_en_a=1. Next state FETCH.
- EXEC, LOAD: pc_sel=0, mux_a_sel=IR[3:0]. Next state LOADWB.
- LOADWB: pc_sel=0, mux_a_sel=IR[3:0], alu_sel=0, reg_en=1<<IR[11:8]. Next state FETCH.
- EXEC, JCOND:
  - mux_a_sel=IR[3:0]. If the condition is true: pc_en=1, pc_ld=1.
  - Conditions: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N; 1000 FS F; 1001 FC !F; 1110 UC always; others never.
  - Conditions evaluate PSR, never live flags.
  - Next state FETCH.
- EXEC, NOP: no strobes. Next state FETCH.
- HALT: all strobes 0, halted=1. Leave only via reset.
- opcode=16'h0000 in every non-ALU cycle.
- Latency: ALU/STOR/JCOND/NOP take 3 cycles; LOAD takes 4.
- Reset: state=FETCH, IR=0, PSR=0, halted=0.
  - reset dominates every other event, including mid-LOAD and HALT.
  - While reset is high, reg_en, w_en_a, pc_en, pc_ld and flag_en are forced 0.
- PSR changes only on an ALU-class EXEC.

Test Plan:
- Reset: assert reset 2 cycles, release -> state=0, pc_sel=1, reg_en=0, psr=0, halted=0. Assert reset during LOADWB -> reg_en=0 that cycle; next state=FETCH.
- ADD: instr=16'h0153 (ADD R1,R3) in DECODE -> EXEC: mux_a_sel=1, mux_b_sel=3, alu_sel=1, reg_en=16'h0002, flag_en=1, opcode=16'h0153; back to FETCH after 3 cycles total.
- CMP then JCOND:
  - CMP 16'h02B4 with flags=5'b01000 -> reg_en=0, psr=5'b01000.
  - 16'h40C7 (JEQ R7) -> pc_en=1, pc_ld=1, mux_a_sel=7.
  - With psr Z=0, same jump -> pc_ld=0, pc_en=0.
- LOAD/STOR:
  - 16'h4205 -> EXEC: pc_sel=0, mux_a_sel=5; LOADWB: alu_sel=0, reg_en=16'h0004; 4 cycles.
  - 16'h4645 -> w_en_a=1, mux_a_sel=5, mux_b_sel=6.
- Unconditional jump / NOP: 16'h4EC2 -> pc_ld=1 regardless of psr. 16'h7000 -> no strobes, psr unchanged.
- Halt: instr=16'hFFFF -> halted=1, state=4. pc_en=0 for 10 cycles; reset returns state to FETCH.
